ame_pivot_ctrl: RTL and testbench

- Sequences partial-pivot Gaussian elimination of the 6x6 affine-motion-estimation linear system, one column per step.
- Per column: fetches the 6 column entries from the matrix store, then drives the 6-input masked max-abs comparator with already-pivoted rows masked.
- Records the winning row, then hands (column, pivot row) to the elimination datapath and waits for it to finish.
- Flags a singular system when the best available pivot is zero.

---
 rtl/ame_pivot_ctrl_pkg.sv | 19 +
 rtl/ame_pivot_ctrl_if.sv | 44 ++++
 rtl/ame_pivot_ctrl.sv | 115 +++++++++++
 tb/tb_ame_pivot_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ame_pivot_ctrl_pkg.sv
// Shared types and constants for the 6x6 pivot-selection controller.
package ame_pkg;

  localparam int AME_ROWS      = 6;
  localparam int AME_DATA_BITS = 64;
  localparam int AME_IDX_BITS  = 3;

  typedef logic [AME_IDX_BITS-1:0]                    idx_t;
  typedef logic [AME_ROWS-1:0][AME_DATA_BITS-1:0]     col_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    COMP,
    ELIM,
    DONE
  } state_e;

endpackage

// File: rtl/ame_pivot_ctrl_if.sv
// Control/data bundle between the pivot sequencer and its matrix store, comparator and eliminator.
interface ame_pivot_ctrl_if
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS     = AME_DATA_BITS,
  parameter int COMP_DATA_IDX_BITS = AME_IDX_BITS
);
  logic                                     start_i;
  logic                                     busy_o;
  logic                                     done_o;
  logic                                     singular_o;
  logic                                     col_req_o;
  logic [COMP_DATA_IDX_BITS-1:0]            col_idx_o;
  logic [AME_ROWS-1:0][COMP_DATA_BITS-1:0]  col_data_i;
  logic                                     col_vld_i;
  logic                                     comp_init_o;
  logic [AME_ROWS-1:0][COMP_DATA_BITS-1:0]  comp_data_o;
  logic [AME_ROWS-1:0]                      comp_data_mask_o;
  logic                                     comp_done_i;
  logic [COMP_DATA_BITS-1:0]                comp_data_i;
  logic [COMP_DATA_IDX_BITS-1:0]            comp_data_index_i;
  logic                                     elim_start_o;
  logic [COMP_DATA_IDX_BITS-1:0]            elim_col_o;
  logic [COMP_DATA_IDX_BITS-1:0]            elim_row_o;
  logic                                     elim_done_i;
  logic [AME_ROWS-1:0][COMP_DATA_IDX_BITS-1:0] pivot_rows_o;

  modport master (
    input  start_i, col_data_i, col_vld_i, comp_done_i, comp_data_i,
           comp_data_index_i, elim_done_i,
    output busy_o, done_o, singular_o, col_req_o, col_idx_o, comp_init_o,
           comp_data_o, comp_data_mask_o, elim_start_o, elim_col_o,
           elim_row_o, pivot_rows_o
  );

  modport slave (
    output start_i, col_data_i, col_vld_i, comp_done_i, comp_data_i,
           comp_data_index_i, elim_done_i,
    input  busy_o, done_o, singular_o, col_req_o, col_idx_o, comp_init_o,
           comp_data_o, comp_data_mask_o, elim_start_o, elim_col_o,
           elim_row_o, pivot_rows_o
  );

endinterface

// File: rtl/ame_pivot_ctrl.sv
// Partial-pivot sequencer: per column fetch -> masked max-abs compare -> eliminate.
// state | meaning
// IDLE  | waiting for start_i
// FETCH | requesting column k from the matrix store
// COMP  | comparator choosing the largest unused row of column k
// ELIM  | elimination datapath working on (k, pivot row)
// DONE  | one-cycle completion pulse
module ame_pivot_ctrl
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS     = AME_DATA_BITS,
  parameter int COMP_DATA_IDX_BITS = AME_IDX_BITS
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  ame_pivot_ctrl_if.master bus
);

  localparam logic [COMP_DATA_IDX_BITS-1:0] LAST_COL = COMP_DATA_IDX_BITS'(AME_ROWS - 1);

  state_e                                   state;
  logic [COMP_DATA_IDX_BITS-1:0]            k;
  logic [AME_ROWS-1:0]                      mask;
  logic [AME_ROWS-1:0][COMP_DATA_BITS-1:0]  col_q;
  logic                                     pick_ok;

  assign bus.col_idx_o        = k;
  assign bus.comp_data_o      = col_q;
  assign bus.comp_data_mask_o = mask;

  // A zero maximum, an out-of-range row or an already-used row all mean no usable pivot.
  always_comb begin
    pick_ok = 1'b0;
    if (bus.comp_data_i != '0 && bus.comp_data_index_i <= LAST_COL)
      pick_ok = !mask[bus.comp_data_index_i];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      k                <= '0;
      mask             <= '0;
      col_q            <= '0;
      bus.busy_o       <= 1'b0;
      bus.done_o       <= 1'b0;
      bus.singular_o   <= 1'b0;
      bus.col_req_o    <= 1'b0;
      bus.comp_init_o  <= 1'b0;
      bus.elim_start_o <= 1'b0;
      bus.elim_col_o   <= '0;
      bus.elim_row_o   <= '0;
      bus.pivot_rows_o <= '0;
    end else begin
      bus.done_o       <= 1'b0;
      bus.comp_init_o  <= 1'b0;
      bus.elim_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            mask             <= '0;
            k                <= '0;
            bus.pivot_rows_o <= '0;
            bus.singular_o   <= 1'b0;
            bus.busy_o       <= 1'b1;
            bus.col_req_o    <= 1'b1;
            state            <= FETCH;
          end
        end
        FETCH: begin
          if (bus.col_vld_i) begin
            col_q           <= bus.col_data_i;
            bus.col_req_o   <= 1'b0;
            bus.comp_init_o <= 1'b1;
            state           <= COMP;
          end
        end
        COMP: begin
          if (bus.comp_done_i) begin
            if (!pick_ok) begin
              bus.singular_o <= 1'b1;
              bus.done_o     <= 1'b1;
              state          <= DONE;
            end else begin
              bus.pivot_rows_o[k]           <= bus.comp_data_index_i;
              mask[bus.comp_data_index_i]   <= 1'b1;
              bus.elim_row_o                <= bus.comp_data_index_i;
              bus.elim_col_o                <= k;
              bus.elim_start_o              <= 1'b1;
              state                         <= ELIM;
            end
          end
        end
        ELIM: begin
          // elim_done_i is meaningless in the cycle the start pulse is still out
          if (!bus.elim_start_o && bus.elim_done_i) begin
            if (k == LAST_COL) begin
              bus.done_o <= 1'b1;
              state      <= DONE;
            end else begin
              k             <= k + 1'b1;
              bus.col_req_o <= 1'b1;
              state         <= FETCH;
            end
          end
        end
        DONE: begin
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ame_pivot_ctrl.sv
// Directed bench for ame_pivot_ctrl with behavioural store, comparator and eliminator responders.
module tb_ame_pivot_ctrl;
  import ame_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ame_pivot_ctrl_if #(.COMP_DATA_BITS(64), .COMP_DATA_IDX_BITS(3)) bus ();

  ame_pivot_ctrl #(.COMP_DATA_BITS(64), .COMP_DATA_IDX_BITS(3)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [63:0] mat [AME_ROWS][AME_ROWS];  // [column][row]
  int vld_dly  = 0;
  int comp_dly = 0;
  int elim_dly = 1;
  bit elim_early = 1'b0;
  int n_init, n_estart, n_done, n_unstable;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_identity();
    for (int c = 0; c < AME_ROWS; c++)
      for (int r = 0; r < AME_ROWS; r++)
        mat[c][r] = (r == c) ? 64'sd5 : 64'sd0;
  endtask

  task automatic load_reverse();
    for (int c = 0; c < AME_ROWS; c++)
      for (int r = 0; r < AME_ROWS; r++)
        mat[c][r] = (r == 5 - c) ? -64'sd9 : (((r + c) % 2) != 0 ? 64'sd1 : -64'sd1);
  endtask

  task automatic load_singular();
    load_identity();
    for (int r = 0; r < AME_ROWS; r++)
      mat[2][r] = (r < 2) ? 64'sd7 : 64'sd0;
  endtask

  // Responders: matrix store, masked max-abs comparator, elimination datapath.
  initial begin
    int vc, cc, ec;
    bit c_act, e_act;
    col_vec_t snap;
    logic [5:0] msnap;
    logic signed [63:0] v, a, best;
    idx_t bi;
    vc = 0; cc = 0; ec = 0; c_act = 0; e_act = 0;
    snap = '0; msnap = '0;
    bus.col_vld_i = 0; bus.col_data_i = '0;
    bus.comp_done_i = 0; bus.comp_data_i = '0; bus.comp_data_index_i = '0;
    bus.elim_done_i = 0;
    forever begin
      @(negedge clk);
      bus.col_vld_i = 1'b0;
      for (int r = 0; r < AME_ROWS; r++) bus.col_data_i[r] = 64'hBAD0_0000_0000_0BAD;
      if (bus.col_req_o) begin
        if (vc == vld_dly) begin
          bus.col_vld_i = 1'b1;
          for (int r = 0; r < AME_ROWS; r++) bus.col_data_i[r] = mat[bus.col_idx_o][r];
        end else vc++;
      end else vc = 0;

      bus.comp_done_i = 1'b0;
      if (bus.comp_init_o) begin
        c_act = 1; cc = 0; n_init++;
        snap = bus.comp_data_o; msnap = bus.comp_data_mask_o;
      end
      if (c_act) begin
        if (bus.comp_data_o !== snap || bus.comp_data_mask_o !== msnap) n_unstable++;
        if (cc == comp_dly) begin
          best = 0; bi = '0;
          for (int r = 0; r < AME_ROWS; r++) begin
            v = bus.comp_data_o[r];
            a = (v < 0) ? -v : v;
            if (!bus.comp_data_mask_o[r] && a > best) begin best = a; bi = idx_t'(r); end
          end
          bus.comp_done_i = 1'b1; bus.comp_data_i = best; bus.comp_data_index_i = bi;
          c_act = 0;
        end else cc++;
      end

      bus.elim_done_i = 1'b0;
      if (bus.elim_start_o) begin
        e_act = 1; ec = 0; n_estart++;
        if (elim_early) bus.elim_done_i = 1'b1;
      end
      if (e_act) begin
        if (ec == elim_dly) begin bus.elim_done_i = 1'b1; e_act = 0; end
        else ec++;
      end
      if (bus.done_o) n_done++;
    end
  end

  task automatic run_solve(input string name, input logic [5:0][2:0] exp_piv,
                           input bit exp_sing, input logic [5:0] exp_mask,
                           input int exp_est, input int exp_cyc, input int poke_col);
    int cyc;
    bit got_done;
    cyc = 0; got_done = 0;
    n_init = 0; n_estart = 0; n_done = 0; n_unstable = 0;
    bus.start_i = 1'b1;
    while (cyc < 400 && !got_done) begin
      @(negedge clk);
      cyc++;
      bus.start_i = 1'b0;
      if (poke_col >= 0 && bus.elim_start_o && int'(bus.elim_col_o) == poke_col) bus.start_i = 1'b1;
      if (bus.done_o) begin
        got_done = 1;
        check({name, " busy@done"}, bus.busy_o, 1'b1);
      end
    end
    check({name, " done seen"}, got_done, 1'b1);
    check({name, " cycles"}, cyc, exp_cyc);
    check({name, " singular"}, bus.singular_o, exp_sing);
    check({name, " mask"}, bus.comp_data_mask_o, exp_mask);
    for (int i = 0; i < AME_ROWS; i++)
      check($sformatf("%s piv%0d", name, i), bus.pivot_rows_o[i], exp_piv[i]);
    repeat (3) @(negedge clk);
    check({name, " busy after"}, bus.busy_o, 1'b0);
    check({name, " done pulses"}, n_done, 1);
    check({name, " elim pulses"}, n_estart, exp_est);
    check({name, " init pulses"}, n_init, exp_est + (exp_sing ? 1 : 0));
    check({name, " comp stable"}, n_unstable, 0);
    check({name, " singular held"}, bus.singular_o, exp_sing);
  endtask

  localparam logic [5:0][2:0] PIV_ID  = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [5:0][2:0] PIV_REV = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  localparam logic [5:0][2:0] PIV_SNG = {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};

  initial begin
    bit found;
    bus.start_i = 1'b0;
    load_identity();
    repeat (3) @(negedge clk);
    check("rst busy", bus.busy_o, 1'b0);
    check("rst done", bus.done_o, 1'b0);
    check("rst col_req", bus.col_req_o, 1'b0);
    check("rst pivots", bus.pivot_rows_o, '0);
    check("rst mask", bus.comp_data_mask_o, '0);
    check("rst comp_data", bus.comp_data_o[0], '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_solve("ident", PIV_ID, 1'b0, 6'h3F, 6, 25, -1);

    load_reverse();
    run_solve("rev", PIV_REV, 1'b0, 6'h3F, 6, 25, -1);

    load_singular();
    run_solve("sing", PIV_SNG, 1'b1, 6'h03, 2, 11, -1);

    load_reverse();
    vld_dly = 3; comp_dly = 2; elim_dly = 5;
    run_solve("stall", PIV_REV, 1'b0, 6'h3F, 6, 79, -1);
    vld_dly = 0; comp_dly = 0; elim_dly = 1;

    load_identity();
    elim_early = 1'b1;
    run_solve("early_elim", PIV_ID, 1'b0, 6'h3F, 6, 25, -1);
    elim_early = 1'b0;

    run_solve("poke", PIV_ID, 1'b0, 6'h3F, 6, 25, 3);

    load_reverse();
    n_done = 0;
    found = 0;
    bus.start_i = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (bus.col_req_o && bus.col_idx_o == 3'd4) found = 1;
    end
    check("abort reached fetch4", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort busy", bus.busy_o, 1'b0);
    check("abort col_req", bus.col_req_o, 1'b0);
    check("abort col_idx", bus.col_idx_o, '0);
    check("abort pivots", bus.pivot_rows_o, '0);
    check("abort mask", bus.comp_data_mask_o, '0);
    check("abort elim_row", bus.elim_row_o, '0);
    repeat (3) @(negedge clk);
    check("abort no done", n_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    load_identity();
    run_solve("post_rst", PIV_ID, 1'b0, 6'h3F, 6, 25, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
